pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer_pkg.sv | 28 ++
 rtl/pll_reset_sequencer_sync2.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_MEM_UP    = 3'd2,
    ST_RUN       = 3'd3,
    ST_PLL_RESET = 3'd4
  } pll_seq_state_t;

  localparam int unsigned DEF_LOCK_CYCLES    = 1024;
  localparam int unsigned DEF_STAGE_CYCLES   = 64;
  localparam int unsigned DEF_CEN_DIV        = 16;
  localparam int unsigned DEF_TIMEOUT        = 1048576;
  localparam int unsigned DEF_PLL_RST_CYCLES = 16;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL lock -> memory reset release -> CPU reset release, with PLL
// re-reset on lock timeout and a clock-enable strobe while running.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int unsigned STAGE_CYCLES   = DEF_STAGE_CYCLES,
  parameter int unsigned CEN_DIV        = DEF_CEN_DIV,
  parameter int unsigned TIMEOUT        = DEF_TIMEOUT,
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           locked_in,
  output logic           pll_rst,
  output logic           mem_rst,
  output logic           cpu_rst,
  output logic           ready,
  output logic           cen,
  output pll_seq_state_t dbg_state
);

  localparam int unsigned CNT_MAX = max4(LOCK_CYCLES, STAGE_CYCLES, TIMEOUT, PLL_RST_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W   = $clog2(CEN_DIV);

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CEN_DIV - 1);

  pll_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             locked_s;

  sync2 u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d_i (locked_in),
    .q_o (locked_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  // Lock loss outranks every other transition in the locked states; cnt only
  // advances up to its terminal value, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = '0;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_MEM_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MEM_UP: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STAGE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
      end
      ST_PLL_RESET: begin
        if (cnt_q == PLLRST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pll_rst = 1'b0;
    mem_rst = 1'b1;
    cpu_rst = 1'b1;
    ready   = 1'b0;
    unique case (state_q)
      ST_WAIT_LOCK: ;
      ST_STABLE:    ;
      ST_MEM_UP:    mem_rst = 1'b0;
      ST_RUN: begin
        mem_rst = 1'b0;
        cpu_rst = 1'b0;
        ready   = 1'b1;
      end
      ST_PLL_RESET: pll_rst = 1'b1;
      default:      ;
    endcase
  end

  assign cen       = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: lock-history reference model feeding an
// expected-output queue, directed timing checks, then random lock/reset traffic.
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  localparam int L  = 8;
  localparam int S  = 4;
  localparam int C  = 4;
  localparam int TO = 32;
  localparam int P  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked_in = 1'b0;
  logic pll_rst, mem_rst, cpu_rst, ready, cen;
  pll_seq_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  pll_reset_sequencer #(
    .LOCK_CYCLES(L), .STAGE_CYCLES(S), .CEN_DIV(C), .TIMEOUT(TO), .PLL_RST_CYCLES(P)
  ) dut (
    .clk(clk), .rst(rst), .locked_in(locked_in),
    .pll_rst(pll_rst), .mem_rst(mem_rst), .cpu_rst(cpu_rst),
    .ready(ready), .cen(cen), .dbg_state(dbg_state)
  );

  // Reference model: outputs follow from how long the synchronized lock has
  // been continuously seen (lock_run), how long it has been missing
  // (wait_len) and any PLL reset pulse still in progress.
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  int   lock_run = 0, wait_len = 0, pulse_left = 0;

  always @(posedge clk) begin
    logic ls, e_ready, e_cen;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0;
      lock_run = 0; wait_len = 0; pulse_left = 0;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = locked_in;
      if (pulse_left > 0) begin
        pulse_left--;
      end else if (ls) begin
        lock_run++;
        wait_len = 0;
      end else if (lock_run > 0) begin
        lock_run = 0;
        wait_len = 0;
      end else begin
        wait_len++;
        if (wait_len == TO) begin
          pulse_left = P;
          wait_len = 0;
        end
      end
    end
    e_ready = (lock_run >= L + S + 1);
    e_cen   = e_ready && (((lock_run - (L + S)) % C) == 0);
    exp_q.push_back({pulse_left > 0, !(lock_run >= L + 1), !e_ready, e_ready, e_cen});
  end

  // scoreboard monitor
  always @(posedge clk) begin
    logic [4:0] e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {pll_rst, mem_rst, cpu_rst, ready, cen};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: {pll,mem,cpu,ready,cen} got %b expected %b", $time, g, e);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0: return !mem_rst;
      1: return ready;
      2: return cen;
      3: return cpu_rst;
      4: return pll_rst;
      default: return !pll_rst;
    endcase
  endfunction

  // Counts rising edges until the selected condition holds; -1 if the bound expires.
  task automatic wait_for(input int sel, input int limit, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (probe(sel)) break;
      if (n >= limit) begin
        n = -1;
        break;
      end
    end
  endtask

  // driver
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_state", int'(dbg_state), int'(ST_WAIT_LOCK));

    // release sequence
    rst = 1'b0;
    locked_in = 1'b1;
    wait_for(0, 100, n); check("rel_mem_rst_fall", n, 11);
    wait_for(1, 100, n); check("rel_ready_rise", n, 4);
    wait_for(2, 100, n); check("rel_first_cen", n, 3);
    wait_for(2, 100, n); check("rel_second_cen", n, 4);
    wait_for(2, 100, n); check("rel_third_cen", n, 4);
    repeat (5) @(negedge clk);

    // lock loss in RUN
    locked_in = 1'b0;
    wait_for(3, 100, n); check("loss_latency_le3", int'(n >= 1 && n <= 3), 1);
    check("loss_mem_rst", int'(mem_rst), 1);
    check("loss_ready", int'(ready), 0);
    repeat (6) @(negedge clk);
    locked_in = 1'b1;
    wait_for(1, 100, n); check("relock_ready", n, 15);
    wait_for(2, 100, n); check("relock_div_restart", n, 3);

    // glitch during STABLE
    @(negedge clk);
    locked_in = 1'b0;
    repeat (5) @(negedge clk);
    locked_in = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_in_stable", int'(dbg_state), int'(ST_STABLE));
    locked_in = 1'b0;
    repeat (2) @(negedge clk);
    locked_in = 1'b1;
    wait_for(0, 100, n); check("glitch_full_restart", n, 11);

    // reset pulse in MEM_UP
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("memup_rst_state", int'(dbg_state), int'(ST_WAIT_LOCK));
    check("memup_rst_mem", int'(mem_rst), 1);
    check("memup_rst_cpu", int'(cpu_rst), 1);
    @(negedge clk);
    rst = 1'b0;
    wait_for(1, 100, n); check("memup_rst_relatency", n, 15);

    // timeout and PLL reset pulse
    @(negedge clk);
    rst = 1'b1;
    locked_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_for(4, 200, n); check("timeout_pll_start", n, TO);
    wait_for(5, 100, n); check("pll_pulse_width", n, P);
    wait_for(4, 200, n); check("pll_pulse_repeat", n + P, TO + P);

    // random lock and reset traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if (locked_in ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0))
        locked_in = ~locked_in;
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
